// File: rtl/mem_ldst_unit_pkg.sv
// Shared types for the load/store access unit: size codes, FSM states, request payload.
package mem_ldst_unit_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_e;

    typedef struct packed {
        logic              we;
        size_e             size;
        logic              uns;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } ldst_req_t;

endpackage

// File: rtl/mem_ldst_unit_lane_align.sv
// Combinational lane logic: store byte enables/replication, load extraction/extension, misalign detect.
module mem_ldst_unit_lane_align
    import mem_ldst_unit_pkg::*;
(
    input  logic              i_we,
    input  size_e             i_size,
    input  logic              i_unsigned,
    input  logic [1:0]        i_addr_lo,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [BE_W-1:0]   o_be_c,
    output logic [DATA_W-1:0] o_wdata_c,
    output logic [DATA_W-1:0] o_ldata_c,
    output logic              o_misalign_c
);

    logic [DATA_W-1:0] w_rshift;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;

    // Byte lane selected by the low address bits; half lane by addr[1].
    assign w_rshift = i_rdata >> {i_addr_lo, 3'b000};
    assign w_byte   = w_rshift[7:0];
    assign w_half   = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Per-size lane mapping; loads never assert byte enables.
    always_comb begin
        o_be_c       = '0;
        o_wdata_c    = i_wdata;
        o_ldata_c    = i_rdata;
        o_misalign_c = 1'b0;
        case (i_size)
            SIZE_B: begin
                o_be_c    = 4'b0001 << i_addr_lo;
                o_wdata_c = {4{i_wdata[7:0]}};
                o_ldata_c = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            SIZE_H: begin
                o_misalign_c = i_addr_lo[0];
                o_be_c       = 4'b0011 << i_addr_lo;
                o_wdata_c    = {2{i_wdata[15:0]}};
                o_ldata_c    = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            end
            SIZE_W: begin
                o_misalign_c = (i_addr_lo != 2'b00);
                o_be_c       = 4'b1111;
            end
            SIZE_X: begin
                o_misalign_c = 1'b1;
            end
            default: begin
                o_misalign_c = 1'b1;
            end
        endcase
        if (!i_we) begin
            o_be_c = '0;
        end
    end

endmodule

// File: rtl/mem_ldst_unit.sv
// Load/store access unit: accepts one request in IDLE, runs a word-aligned memory
// access with timeout, and returns an extended load result with a done/err pulse.
module mem_ldst_unit
    import mem_ldst_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic [BE_W-1:0]   mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    ldst_req_t         r_req;
    ldst_req_t         w_req_in;
    ldst_req_t         w_req_eff;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_err_nxt;
    logic              w_load_rdata;
    logic              w_accept;
    logic [BE_W-1:0]   w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_ldata;
    logic              w_misalign;

    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic              r_mem_en;
    logic [BE_W-1:0]   r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    // In IDLE the lane logic looks at the incoming request, afterwards at the latched one.
    assign w_req_in  = '{we: req_we, size: size_e'(req_size), uns: req_unsigned,
                         addr: req_addr, wdata: req_wdata};
    assign w_req_eff = (r_state == IDLE) ? w_req_in : r_req;
    assign w_accept  = (r_state == IDLE) && req_valid;

    mem_ldst_unit_lane_align u_lane_align (
        .i_we        (w_req_eff.we),
        .i_size      (w_req_eff.size),
        .i_unsigned  (w_req_eff.uns),
        .i_addr_lo   (w_req_eff.addr[1:0]),
        .i_wdata     (w_req_eff.wdata),
        .i_rdata     (mem_rdata),
        .o_be_c      (w_be),
        .o_wdata_c   (w_wdata),
        .o_ldata_c   (w_ldata),
        .o_misalign_c(w_misalign)
    );

    // Next-state, timeout counter and completion decisions.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_err_nxt    = 1'b0;
        w_load_rdata = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (req_valid) begin
                    if (w_misalign) begin
                        w_state_nxt = DONE;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    w_state_nxt  = DONE;
                    w_load_rdata = !r_req.we;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DONE;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counter, request latch and load result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_req   <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_req <= w_req_in;
            end
            if (w_load_rdata) begin
                r_rdata <= w_ldata;
            end
        end
    end

    // Registered outputs decoded from the upcoming state; memory port held stable through ACCESS.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_busy   <= (w_state_nxt != IDLE);
            r_done   <= (w_state_nxt == DONE);
            r_err    <= w_err_nxt;
            r_mem_en <= (w_state_nxt == ACCESS);
            r_mem_we <= (w_state_nxt == ACCESS) ? w_be : '0;
            if (w_state_nxt == ACCESS) begin
                r_mem_addr  <= {w_req_eff.addr[ADDR_W-1:2], 2'b00};
                r_mem_wdata <= w_wdata;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_ldst_unit.sv
// Self-checking bench for mem_ldst_unit: directed vectors plus randomized transactions
// compared against a transaction-level reference model.
module tb_mem_ldst_unit;

    localparam int unsigned TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] model_rdata = 32'h0;

    mem_ldst_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .rdata       (rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: rules stated as arithmetic on byte counts and offsets.
    function automatic bit f_misalign(input logic [1:0] size, input logic [31:0] addr);
        int unsigned nbytes;
        if (size == 2'b11) return 1'b1;
        nbytes = 1 << size;
        return (addr % nbytes) != 0;
    endfunction

    function automatic logic [3:0] f_be(input logic we, input logic [1:0] size, input logic [31:0] addr);
        logic [3:0] be = 4'h0;
        int unsigned o = addr % 4;
        int unsigned n = 1 << size;
        if (!we) return 4'h0;
        for (int l = 0; l < 4; l++) begin
            if (l >= o && l < o + n) be[l] = 1'b1;
        end
        return be;
    endfunction

    function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] d);
        int unsigned b = d % 256;
        int unsigned h = d % 65536;
        if (size == 2'b00) return b * 32'h01010101;
        if (size == 2'b01) return h * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] f_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr, input logic [31:0] w);
        int unsigned o = addr % 4;
        int unsigned v;
        if (size == 2'b00) begin
            v = (w >> (8 * o)) % 256;
            if (!uns && v >= 128) v = v + 32'hFFFFFF00;
        end else if (size == 2'b01) begin
            v = (w >> (8 * o)) % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // One request from IDLE through DONE; ack_at = 0 means memory never answers.
    task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int ack_at, input logic [31:0] rd_word, input bit spam);
        bit acked = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'h0);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_we = 1'($urandom); req_size = 2'($urandom);
        if (f_misalign(size, addr)) begin
            check("mis_done", 32'(done), 32'h1);
            check("mis_err", 32'(err), 32'h1);
            check("mis_mem_en", 32'(mem_en), 32'h0);
            check("mis_rdata", rdata, model_rdata);
            @(negedge clk);
            check("mis_done_pulse", 32'(done), 32'h0);
            check("mis_busy_after", 32'(busy), 32'h0);
            return;
        end
        for (int i = 1; i <= int'(TIMEOUT); i++) begin
            check("acc_mem_en", 32'(mem_en), 32'h1);
            check("acc_busy", 32'(busy), 32'h1);
            check("acc_done", 32'(done), 32'h0);
            check("acc_mem_we", 32'(mem_we), 32'(f_be(we, size, addr)));
            check("acc_mem_addr", mem_addr, addr & 32'hFFFFFFFC);
            if (we) check("acc_mem_wdata", mem_wdata, f_wdata(size, wd));
            if (spam) begin
                req_valid = 1'b1; req_addr = $urandom; req_wdata = $urandom;
                req_we = 1'($urandom); req_size = 2'($urandom);
            end
            if (i == ack_at) begin
                mem_ack = 1'b1; mem_rdata = rd_word; acked = 1'b1;
            end else begin
                mem_ack = 1'b0; mem_rdata = $urandom;
            end
            @(negedge clk);
            mem_ack = 1'b0; req_valid = 1'b0; mem_rdata = $urandom;
            if (acked) break;
        end
        if (acked && !we) model_rdata = f_load(size, uns, addr, rd_word);
        check("end_done", 32'(done), 32'h1);
        check("end_err", 32'(err), 32'(!acked));
        check("end_mem_en", 32'(mem_en), 32'h0);
        check("end_mem_we", 32'(mem_we), 32'h0);
        check("end_rdata", rdata, model_rdata);
        @(negedge clk);
        check("post_done", 32'(done), 32'h0);
        check("post_busy", 32'(busy), 32'h0);
        check("post_mem_en", 32'(mem_en), 32'h0);
    endtask

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
        rst = 1'b1;
        #3 rst = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Directed vectors
        run_txn(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 1, 32'h0, 1'b0);
        run_txn(1'b1, 2'b00, 1'b0, 32'h103, 32'h000000A5, 2, 32'h0, 1'b0);
        run_txn(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 4, 32'h1280FF00, 1'b0);
        check("lb_const", rdata, 32'hFFFFFF80);
        run_txn(1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 4, 32'h1280FF00, 1'b0);
        check("lbu_const", rdata, 32'h00000080);
        run_txn(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 1, 32'h0, 1'b0);
        run_txn(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1, 32'h0, 1'b0);
        run_txn(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1, 32'h0, 1'b0);
        check("mis_keep_const", rdata, 32'h00000080);
        run_txn(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 0, 32'h0, 1'b0);
        run_txn(1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 16, 32'h8001C0DE, 1'b1);

        // Reset in the middle of a halfword store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_addr = 32'h302; req_wdata = 32'h1234ABCD;
        @(negedge clk);
        req_valid = 1'b0;
        check("sh_mem_we", 32'(mem_we), 32'hC);
        check("sh_mem_wdata", mem_wdata, 32'hABCDABCD);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        model_rdata = 32'h0;
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_done", 32'(done), 32'h0);
        check("arst_err", 32'(err), 32'h0);
        check("arst_mem_en", 32'(mem_en), 32'h0);
        check("arst_mem_we", 32'(mem_we), 32'h0);
        check("arst_rdata", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("arst_no_done", 32'(done), 32'h0);
        check("arst_idle", 32'(busy), 32'h0);

        // Randomized transactions
        for (int t = 0; t < 150; t++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            int          ack_at;
            int unsigned r;
            sz = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((32'h1 << sz) - 32'h1);
            r  = $urandom_range(0, 19);
            ack_at = (r == 0) ? 0 : (r == 1) ? 16 : int'($urandom_range(1, 5));
            run_txn(1'($urandom), sz, 1'($urandom), a, $urandom, ack_at, $urandom, 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                mem_ack = 1'b1;
                @(negedge clk);
                mem_ack = 1'b0;
                check("stray_ack_idle", 32'(busy), 32'h0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
